irq_encoder_83: RTL and testbench
=================================

Name: irq_encoder_83

Overview:
- Inbound counterpart to the 3-to-8 active-low select decoder. Collects eight active-low request lines and latches falling edges as pending events.
- Presents the pending event with the highest priority as a 3-bit code, using a valid/ack handshake.
- Sits between peripheral request lines and the sequencer/interrupt logic. Gives edge-to-code encoding with no lost or double-counted events.

Parameters:
- LSB_FIRST, 1, 1: bit 0 has the highest priority (code 000 wins). 0: bit 7 has the highest priority.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- req_n  in  8  active-low request lines, already synchronous to clk
- ack  in  1  consumer accepts the presented code; meaningful only while valid=1
- clr_ovr  in  1  clears the overrun register
- valid  out  1  code/onehot_n hold a pending event
- code  out  3  encoded index of the presented event
- onehot_n  out  8  active-low one-hot image of code; 8'hFF when valid=0
- pending  out  8  current pending-event register, active-high
- overrun  out  8  sticky per-line flag: an edge arrived while that line was already pending

Behaviour:
- Reset (reset_n=0 at a rising edge) sets: valid=0, code=0, onehot_n=8'hFF, pending=0, overrun=0, state=IDLE, internal req_q=8'hFF. Reset has priority over all other inputs, and any in-flight event is discarded.
- Edge detect: event[i] = req_q[i] & ~req_n[i]; req_q <= req_n on every edge. A line held low through reset therefore produces one event at the first edge after release.
- Pending update, per bit i, on each edge:
  - set if event[i];
  - else clear if the handshake completes (valid & ack) and code==i;
  - else hold.
  - A new edge on the same bit as the ack in the same cycle: the set wins, so the event is re-pended.
- Overrun: overrun[i] is set when event[i]=1 and pending[i] is already 1, and ack is not clearing bit i that cycle. clr_ovr=1 clears all bits. If a set and clr_ovr occur in the same cycle, the set wins.
- State machine, two states, registered outputs:
  - IDLE (valid=0): if pending!=0 at an edge, load code with the priority encode of pending (per LSB_FIRST), drive onehot_n = ~(1<<code), set valid=1, and go to PRESENT. Events arriving that same cycle are not considered until the next evaluation.
  - PRESENT (valid=1): code and onehot_n are frozen. A higher-priority arrival does not preempt. On ack=1, clear pending[code] (subject to the rule above), set valid=0 and onehot_n=8'hFF, and go to IDLE. On ack=0, hold.
- ack while valid=0 is ignored and has no side effects.
- Latency:
  - req_n sampled low at edge E0 gives pending set after E0 and valid=1 after E1.
  - ack at edge Ea gives valid=0 for at least one cycle. The next event can be valid after Ea+1.
  - Back-to-back throughput is one event per two cycles.
- Invariants:
  - valid=1 implies pending[code]=1.
  - onehot_n is always 8'hFF or has exactly one zero bit.
- Level-held requests generate exactly one event. The line must return high and fall again to create another event.

Test Plan:
- Reset, then req_n=8'hFF for 10 cycles -> valid=0, onehot_n=8'hFF, pending=0, overrun=0 throughout.
- req_n goes from 8'hFF to 8'b1111_0111 and is held -> pending=8'h08 after E0; valid=1, code=3, onehot_n=8'b1111_0111 after E1. Ack once -> valid=0, pending=0. No second event while the line stays low.
- Simultaneous falls on bits 5 and 2, LSB_FIRST=1 -> code=2 first. After ack, code=5 appears two edges later. With LSB_FIRST=0 the order is 5 then 2.
- While code=4 is presented with ack=0, bit 0 falls -> code stays 4, and pending=8'h11. After ack, code=0 is presented.
- Bit 6 falls, rises and falls again before ack -> overrun=8'h40, and pending[6] is still 1. After clr_ovr=1 -> overrun=0.
- Ack of code=1 in the same cycle as a new fall on bit 1 -> pending[1] stays 1, overrun[1] stays 0, and code=1 is re-presented two edges later. Separately, reset_n=0 while valid=1 -> all outputs return to reset values on that edge.

Source files
------------

// File: rtl/irq_encoder_83.sv
// Edge-triggered 8-line interrupt encoder: latches falling edges of active-low
// request lines as pending events and presents the highest-priority one as a code.
module irq_encoder_83 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req_n,
  input  logic       ack,
  input  logic       clr_ovr,
  output logic       valid,
  output logic [2:0] code,
  output logic [7:0] onehot_n,
  output logic [7:0] pending,
  output logic [7:0] overrun
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] req_q_reg;
  logic [7:0] pending_reg, pending_next;
  logic [7:0] overrun_reg, overrun_next;
  logic       valid_reg, valid_next;
  logic [2:0] code_reg, code_next;
  logic [7:0] onehot_n_reg, onehot_n_next;

  logic [7:0] edge_evt;
  logic [7:0] clear_mask;
  logic [7:0] ovr_set;
  logic [2:0] prio_code;
  logic       handshake;

  assign handshake = valid_reg & ack;

  // Per-line bookkeeping; a new edge always beats the ack-driven clear.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
      assign edge_evt[gi]     = req_q_reg[gi] & ~req_n[gi];
      assign clear_mask[gi]   = handshake & (code_reg == 3'(gi));
      assign ovr_set[gi]      = edge_evt[gi] & pending_reg[gi] & ~clear_mask[gi];
      assign pending_next[gi] = edge_evt[gi] | (pending_reg[gi] & ~clear_mask[gi]);
      assign overrun_next[gi] = ovr_set[gi] | (overrun_reg[gi] & ~clr_ovr);
    end
  endgenerate

  // Priority encode of the registered pending set only; same-cycle arrivals wait.
  always_comb begin
    prio_code = 3'd0;
    if (LSB_FIRST) begin
      for (int i = 7; i >= 0; i--) begin
        if (pending_reg[i]) prio_code = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (pending_reg[i]) prio_code = 3'(i);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    valid_next    = valid_reg;
    code_next     = code_reg;
    onehot_n_next = onehot_n_reg;
    case (state_reg)
      IDLE: begin
        if (|pending_reg) begin
          state_next    = PRESENT;
          valid_next    = 1'b1;
          code_next     = prio_code;
          onehot_n_next = ~(8'd1 << prio_code);
        end
      end
      PRESENT: begin
        // Presented code is frozen until accepted; no preemption.
        if (ack) begin
          state_next    = IDLE;
          valid_next    = 1'b0;
          onehot_n_next = 8'hFF;
        end
      end
      default: begin
        state_next    = IDLE;
        valid_next    = 1'b0;
        onehot_n_next = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      req_q_reg    <= 8'hFF;
      pending_reg  <= 8'h00;
      overrun_reg  <= 8'h00;
      valid_reg    <= 1'b0;
      code_reg     <= 3'd0;
      onehot_n_reg <= 8'hFF;
    end else begin
      state_reg    <= state_next;
      req_q_reg    <= req_n;
      pending_reg  <= pending_next;
      overrun_reg  <= overrun_next;
      valid_reg    <= valid_next;
      code_reg     <= code_next;
      onehot_n_reg <= onehot_n_next;
    end
  end

  assign valid    = valid_reg;
  assign code     = code_reg;
  assign onehot_n = onehot_n_reg;
  assign pending  = pending_reg;
  assign overrun  = overrun_reg;

endmodule

// File: tb/tb_irq_encoder_83.sv
// Bench for irq_encoder_83: two instances (LSB-first and MSB-first) checked
// every cycle against an event-level reference model, plus directed scenarios.
module tb_irq_encoder_83;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] req_n;
  logic       ack;
  logic       clr_ovr;

  logic       valid_l, valid_m;
  logic [2:0] code_l, code_m;
  logic [7:0] onehot_l, onehot_m, pending_l, pending_m, overrun_l, overrun_m;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = LSB-first instance, 1 = MSB-first.
  logic [7:0] m_prev;
  logic [7:0] m_pend[2];
  logic [7:0] m_ovr[2];
  bit         m_valid[2];
  int         m_code[2];

  always #5 clk = ~clk;

  irq_encoder_83 #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .req_n(req_n), .ack(ack), .clr_ovr(clr_ovr),
    .valid(valid_l), .code(code_l), .onehot_n(onehot_l),
    .pending(pending_l), .overrun(overrun_l)
  );

  irq_encoder_83 #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset_n(reset_n), .req_n(req_n), .ack(ack), .clr_ovr(clr_ovr),
    .valid(valid_m), .code(code_m), .onehot_n(onehot_m),
    .pending(pending_m), .overrun(overrun_m)
  );

  function automatic int pick(logic [7:0] p, bit lsb_first);
    if (lsb_first) begin
      for (int i = 0; i < 8; i++) if (p[i]) return i;
    end else begin
      for (int i = 7; i >= 0; i--) if (p[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [27:0] expv(int k);
    logic [7:0] oh;
    oh = 8'hFF;
    if (m_valid[k]) oh[m_code[k]] = 1'b0;
    return {m_valid[k], m_valid[k] ? 3'(m_code[k]) : 3'd0, oh, m_pend[k], m_ovr[k]};
  endfunction

  function automatic logic [27:0] obs(int k);
    if (k == 0)
      return {valid_l, m_valid[0] ? code_l : 3'd0, onehot_l, pending_l, overrun_l};
    return {valid_m, m_valid[1] ? code_m : 3'd0, onehot_m, pending_m, overrun_m};
  endfunction

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    logic [7:0] ev, clr, newo;
    @(posedge clk);
    ev = m_prev & ~req_n;
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_pend[k]  = 8'h00;
        m_ovr[k]   = 8'h00;
        m_valid[k] = 1'b0;
        m_code[k]  = 0;
      end else begin
        clr = 8'h00;
        if (m_valid[k] && ack) clr[m_code[k]] = 1'b1;
        newo = ev & m_pend[k] & ~clr;
        m_ovr[k] = clr_ovr ? newo : (m_ovr[k] | newo);
        if (!m_valid[k]) begin
          if (m_pend[k] != 8'h00) begin
            m_valid[k] = 1'b1;
            m_code[k]  = pick(m_pend[k], k == 0);
          end
        end else if (ack) begin
          m_valid[k] = 1'b0;
        end
        m_pend[k] = ev | (m_pend[k] & ~clr);
      end
    end
    m_prev = reset_n ? req_n : 8'hFF;
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; req_n = 8'hFF; ack = 1'b0; clr_ovr = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_n = 8'h00; ack = 1'b1; clr_ovr = 1'b0;
    tick();
    n_checks++;
    if ({valid_l, code_l, onehot_l, pending_l, overrun_l} !== {1'b0, 3'd0, 8'hFF, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_values got v=%0b c=%0d oh=%h p=%h o=%h want v=0 c=0 oh=ff p=00 o=00",
               valid_l, code_l, onehot_l, pending_l, overrun_l);
    end
    reset_n = 1'b1; req_n = 8'hFF; ack = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== expv(k) || expv(k) !== {1'b0, 3'd0, 8'hFF, 8'h00, 8'h00}) begin
          n_fail++;
          $display("FAIL reset_idle inst%0d cyc%0d got %h want %h", k, c, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_single_edge();
    apply_reset();
    req_n = 8'b1111_0111;
    for (int c = 0; c < 9; c++) begin
      ack = (c == 2);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL single_edge inst%0d cyc%0d got %h want %h", k, c, obs(k), expv(k));
        end
      end
      if (c == 0) begin
        n_checks++;
        if (pending_l !== 8'h08 || valid_l !== 1'b0) begin
          n_fail++;
          $display("FAIL single_e0 got p=%h v=%0b want p=08 v=0", pending_l, valid_l);
        end
      end else if (c == 1) begin
        n_checks++;
        if (valid_l !== 1'b1 || code_l !== 3'd3 || onehot_l !== 8'b1111_0111) begin
          n_fail++;
          $display("FAIL single_e1 got v=%0b c=%0d oh=%h want v=1 c=3 oh=f7", valid_l, code_l, onehot_l);
        end
      end else begin
        n_checks++;
        if (valid_l !== 1'b0 || pending_l !== 8'h00) begin
          n_fail++;
          $display("FAIL single_held cyc%0d got v=%0b p=%h want v=0 p=00", c, valid_l, pending_l);
        end
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [2:0] want_l, want_m;
    apply_reset();
    req_n = ~8'h24;
    for (int c = 0; c < 6; c++) begin
      ack = (c == 2 || c == 4);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL simultaneous inst%0d cyc%0d got %h want %h", k, c, obs(k), expv(k));
        end
      end
      if (c == 1 || c == 3) begin
        want_l = (c == 1) ? 3'd2 : 3'd5;
        want_m = (c == 1) ? 3'd5 : 3'd2;
        n_checks++;
        if (valid_l !== 1'b1 || code_l !== want_l || valid_m !== 1'b1 || code_m !== want_m) begin
          n_fail++;
          $display("FAIL simul_order cyc%0d got lsb=%0d msb=%0d want lsb=%0d msb=%0d",
                   c, code_l, code_m, want_l, want_m);
        end
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_no_preempt();
    apply_reset();
    req_n = ~8'h10;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) req_n = ~8'h11;
      ack = (c == 4 || c == 6);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL no_preempt inst%0d cyc%0d got %h want %h", k, c, obs(k), expv(k));
        end
      end
      if (c == 3) begin
        n_checks++;
        if (valid_l !== 1'b1 || code_l !== 3'd4 || pending_l !== 8'h11) begin
          n_fail++;
          $display("FAIL hold_code4 got v=%0b c=%0d p=%h want v=1 c=4 p=11", valid_l, code_l, pending_l);
        end
      end else if (c == 5) begin
        n_checks++;
        if (valid_l !== 1'b1 || code_l !== 3'd0) begin
          n_fail++;
          $display("FAIL next_code0 got v=%0b c=%0d want v=1 c=0", valid_l, code_l);
        end
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] seq[5] = '{~8'h40, 8'hFF, ~8'h40, ~8'h40, ~8'h40};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      req_n   = seq[c];
      clr_ovr = (c == 3);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL overrun inst%0d cyc%0d got %h want %h", k, c, obs(k), expv(k));
        end
      end
      if (c == 2) begin
        n_checks++;
        if (overrun_l !== 8'h40 || pending_l[6] !== 1'b1) begin
          n_fail++;
          $display("FAIL overrun_set got o=%h p=%h want o=40 p[6]=1", overrun_l, pending_l);
        end
      end else if (c == 3) begin
        n_checks++;
        if (overrun_l !== 8'h00) begin
          n_fail++;
          $display("FAIL overrun_clr got o=%h want 00", overrun_l);
        end
      end
    end
    clr_ovr = 1'b0;
  endtask

  task automatic test_ack_refall();
    logic [7:0] seq[5] = '{~8'h02, ~8'h02, 8'hFF, ~8'h02, ~8'h02};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      req_n = seq[c];
      ack   = (c == 3);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL ack_refall inst%0d cyc%0d got %h want %h", k, c, obs(k), expv(k));
        end
      end
      if (c == 3) begin
        n_checks++;
        if (pending_l[1] !== 1'b1 || overrun_l[1] !== 1'b0 || valid_l !== 1'b0) begin
          n_fail++;
          $display("FAIL refall_pend got p=%h o=%h v=%0b want p[1]=1 o[1]=0 v=0",
                   pending_l, overrun_l, valid_l);
        end
      end else if (c == 4) begin
        n_checks++;
        if (valid_l !== 1'b1 || code_l !== 3'd1) begin
          n_fail++;
          $display("FAIL refall_represent got v=%0b c=%0d want v=1 c=1", valid_l, code_l);
        end
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_reset_inflight();
    apply_reset();
    req_n = ~8'h80;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    n_checks++;
    if ({valid_l, code_l, onehot_l, pending_l, overrun_l} !== {1'b0, 3'd0, 8'hFF, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_inflight got v=%0b c=%0d oh=%h p=%h o=%h want v=0 c=0 oh=ff p=00 o=00",
               valid_l, code_l, onehot_l, pending_l, overrun_l);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL held_thru_reset inst%0d cyc%0d got %h want %h", k, c, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] lines;
    apply_reset();
    lines = 8'hFF;
    for (int c = 0; c < 3000; c++) begin
      lines   = lines ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255) & $urandom_range(0, 255));
      req_n   = lines;
      ack     = ($urandom_range(0, 99) < 45);
      clr_ovr = ($urandom_range(0, 99) < 8);
      reset_n = ($urandom_range(0, 199) != 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL random inst%0d cyc%0d got %h want %h", k, c, obs(k), expv(k));
        end
      end
    end
    reset_n = 1'b1; ack = 1'b0; clr_ovr = 1'b0; req_n = 8'hFF;
  endtask

  initial begin
    m_prev = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 8'h00; m_ovr[k] = 8'h00; m_valid[k] = 1'b0; m_code[k] = 0;
    end
    test_reset();
    test_single_edge();
    test_simultaneous();
    test_no_preempt();
    test_overrun();
    test_ack_refall();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
